// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin arbiter that issues {a, b, sel} to one shared ALU
// and returns result/carry on the requesting channel's response port.
module alu_arbiter_2ch #(
  parameter int DW = 4,
  parameter int SW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_sel,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic [DW-1:0] resp0_result,
  output logic          resp0_carry,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [DW-1:0] resp1_result,
  output logic          resp1_carry,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  output logic          busy,
  output logic [CW-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  logic   gnt_q, prio_q;
  logic   pick, req_fire, resp_fire;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Requesters hold valid and payload until ready; responses hold valid,
  // result and carry stable until the consumer's ready.
  always_comb begin
    pick = prio_q;
    if (req0_valid && !req1_valid) pick = 1'b0;
    else if (req1_valid && !req0_valid) pick = 1'b1;
    req_fire   = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = req_fire && !pick;
    req1_ready = req_fire && pick;
    resp_fire  = (state_q == RESP) && (gnt_q ? resp1_ready : resp0_ready);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q        <= 1'b0;
      prio_q       <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_carry  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_carry  <= 1'b0;
      done_count   <= '0;
    end else begin
      if (req_fire) begin
        gnt_q   <= pick;
        alu_a   <= pick ? req1_a   : req0_a;
        alu_b   <= pick ? req1_b   : req0_b;
        alu_sel <= pick ? req1_sel : req0_sel;
      end
      // The ALU is combinational, so its outputs settle during EXEC.
      if (state_q == EXEC) begin
        if (gnt_q) begin
          resp1_valid  <= 1'b1;
          resp1_result <= alu_result;
          resp1_carry  <= alu_carry;
        end else begin
          resp0_valid  <= 1'b1;
          resp0_result <= alu_result;
          resp0_carry  <= alu_carry;
        end
      end
      if (resp_fire) begin
        prio_q      <= ~gnt_q;
        done_count  <= done_count + 1'b1;
        resp0_valid <= 1'b0;
        resp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Directed bench for alu_arbiter_2ch with a local behavioural 4-bit ALU.
module tb_alu_arbiter_2ch;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       resp0_valid, resp0_ready, resp0_carry;
  logic       resp1_valid, resp1_ready, resp1_carry;
  logic [3:0] resp0_result, resp1_result;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry, busy;
  logic [7:0] done_count;

  int total = 0;
  int bad = 0;
  int exp_done = 0;

  alu_arbiter_2ch dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_carry(resp0_carry),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_carry(resp1_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy), .done_count(done_count)
  );

  // Shared ALU stand-in: add, sub, and, or, xor, not a, shl, shr.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = alu_a + alu_b;
      3'd1: {alu_carry, alu_result} = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: {alu_carry, alu_result} = {alu_a, 1'b0};
      default: {alu_result, alu_carry} = {1'b0, alu_a};
    endcase
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    exp_done = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_count, 0);
    chk("rst_r0v", resp0_valid, 0);
    chk("rst_r1v", resp1_valid, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_req(input int ch, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel, input logic v);
    if (ch == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  // Full single-channel transaction starting in IDLE at a negedge.
  task automatic do_op(input int ch, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel, input logic [3:0] r, input logic c);
    @(negedge clk);
    drive_req(ch, a, b, sel, 1'b1);
    #1;
    chk("op_ready", (ch == 0) ? req0_ready : req1_ready, 1);
    chk("op_other_ready", (ch == 0) ? req1_ready : req0_ready, 0);
    @(posedge clk); #1;
    drive_req(ch, 4'h0, 4'h0, 3'h0, 1'b0);
    chk("op_alu_in", {alu_a, alu_b, 1'b0, alu_sel}, {a, b, 1'b0, sel});
    chk("op_exec_valid", {resp0_valid, resp1_valid}, 0);
    @(posedge clk); #1;
    chk("op_resp_valid", {resp1_valid, resp0_valid}, (ch == 0) ? 2'b01 : 2'b10);
    chk("op_result", (ch == 0) ? {resp0_carry, resp0_result} : {resp1_carry, resp1_result}, {c, r});
    if (ch == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    exp_done++;
    chk("op_done_count", done_count, exp_done % 256);
    chk("op_idle", {busy, resp0_valid, resp1_valid}, 0);
  endtask

  typedef struct {
    int         ch;
    logic [3:0] a, b;
    logic [2:0] sel;
    logic [3:0] r;
    logic       c;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 4'h5, 4'h3, 3'd0, 4'h8, 1'b0};
    vecs[1]  = '{1, 4'h9, 4'h8, 3'd0, 4'h1, 1'b1};
    vecs[2]  = '{0, 4'hF, 4'h1, 3'd0, 4'h0, 1'b1};
    vecs[3]  = '{1, 4'h3, 4'h5, 3'd1, 4'hE, 1'b1};
    vecs[4]  = '{0, 4'h7, 4'h2, 3'd1, 4'h5, 1'b0};
    vecs[5]  = '{1, 4'h5, 4'h3, 3'd2, 4'h1, 1'b0};
    vecs[6]  = '{0, 4'h5, 4'h3, 3'd3, 4'h7, 1'b0};
    vecs[7]  = '{1, 4'hC, 4'hA, 3'd4, 4'h6, 1'b0};
    vecs[8]  = '{0, 4'hA, 4'h0, 3'd5, 4'h5, 1'b0};
    vecs[9]  = '{1, 4'h9, 4'h0, 3'd6, 4'h2, 1'b1};
    vecs[10] = '{0, 4'h9, 4'h0, 3'd7, 4'h4, 1'b1};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    resp0_ready = 0; resp1_ready = 0;
    #1;
    chk("init_alu", {alu_a, alu_b, 1'b0, alu_sel}, 0);
    chk("init_ready", {req0_ready, req1_ready}, 0);
    chk("init_resp", {resp0_valid, resp0_carry, resp0_result, resp1_valid, resp1_carry, resp1_result}, 0);
    do_reset();

    // Table-driven single-channel operations.
    for (int i = 0; i < 11; i++)
      do_op(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].r, vecs[i].c);

    // Backpressure on channel 1 while channel 0 waits.
    @(negedge clk);
    drive_req(1, 4'h9, 4'h8, 3'd0, 1'b1);
    @(posedge clk); #1;
    drive_req(1, 4'h0, 4'h0, 3'd0, 1'b0);
    for (int k = 0; k < 10 && !resp1_valid; k++) @(negedge clk);
    chk("bp_resp_seen", resp1_valid, 1);
    drive_req(0, 4'h5, 4'h3, 3'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {resp1_valid, resp1_carry, resp1_result, req0_ready}, {1'b1, 1'b1, 4'h1, 1'b0});
    end
    resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp1_ready = 1'b0;
    req0_valid = 1'b0;
    exp_done++;
    chk("bp_done_count", done_count, exp_done);
    chk("bp_released", resp1_valid, 0);

    // Asynchronous reset while a response is held.
    @(negedge clk);
    drive_req(0, 4'h7, 4'h6, 3'd4, 1'b1);
    @(posedge clk); #1;
    drive_req(0, 4'h0, 4'h0, 3'd0, 1'b0);
    @(posedge clk); #3;
    chk("ar_pre_valid", resp0_valid, 1);
    rst = 1'b1;
    exp_done = 0;
    #1;
    chk("ar_resp0", {resp0_valid, resp0_carry, resp0_result}, 0);
    chk("ar_alu", {alu_a, alu_b, 1'b0, alu_sel}, 0);
    chk("ar_busy_done", {busy, done_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests: grants alternate starting with channel 0.
    drive_req(0, 4'h5, 4'h3, 3'd2, 1'b1);
    drive_req(1, 4'h5, 4'h3, 3'd3, 1'b1);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      int got;
      got = -1;
      for (int k = 0; k < 8 && got < 0; k++) begin
        #1;
        if (req0_ready || req1_ready) got = req1_ready ? 1 : 0;
        else @(negedge clk);
      end
      chk("sim_grant_seen", (got >= 0), 1);
      chk("sim_grant_order", got, g % 2);
      chk("sim_one_ready", req0_ready & req1_ready, 0);
      for (int k = 0; k < 8 && !(resp0_valid || resp1_valid); k++) @(negedge clk);
      chk("sim_resp_ch", {resp1_valid, resp0_valid}, (g % 2) ? 2'b10 : 2'b01);
      chk("sim_result", (g % 2) ? resp1_result : resp0_result, (g % 2) ? 4'h7 : 4'h1);
      if (g == 7) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(posedge clk);
      exp_done++;
      @(negedge clk);
    end
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk("sim_done_count", done_count, exp_done);

    // Reset during EXEC drops the in-flight response and restores prio=0.
    do_op(0, 4'h1, 4'h1, 3'd0, 4'h2, 1'b0);
    @(negedge clk);
    drive_req(1, 4'h3, 4'h3, 3'd0, 1'b1);
    @(posedge clk); #1;
    drive_req(1, 4'h0, 4'h0, 3'd0, 1'b0);
    chk("re_in_exec", busy, 1);
    #1 rst = 1'b1;
    exp_done = 0;
    #1;
    chk("re_cleared", {busy, resp1_valid, done_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("re_no_resp1", resp1_valid, 0);
    end
    resp1_ready = 1'b0;
    drive_req(0, 4'h1, 4'h2, 3'd0, 1'b1);
    drive_req(1, 4'h1, 4'h2, 3'd0, 1'b1);
    #1;
    chk("re_grant_ch0", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Counter wrap after 256 completed operations.
    for (int i = 0; i < 256; i++)
      do_op(i % 2, 4'(i), 4'h1, 3'd0, 4'(i + 1), (i % 16) == 15);
    chk("wrap_zero", done_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
